// File: rtl/ifq_multiline_if.sv
// Bundle of the icache fetch port and the dispatch port of the fetch queue.
// The master modport is the queue itself; the slave modport is the
// surrounding icache/dispatch logic.
interface ifq_multiline_if #(
    parameter int DEPTH = 4,
    parameter int WPL   = 4
);
    localparam int CW = $clog2(DEPTH * WPL) + 1;

    logic [31:0]      icache_pcin;
    logic             icache_ren;
    logic             icache_abort;
    logic [32*WPL-1:0] icache_dout;
    logic             icache_dout_valid;

    logic [31:0]      dispatch_pcout_plus4;
    logic [31:0]      dispatch_inst;
    logic             dispatch_empty;
    logic             dispatch_ren;
    logic [31:0]      dispatch_branch_addr;
    logic             dispatch_branch_valid;
    logic [CW-1:0]    ifq_count;

    modport master (
        output icache_pcin, icache_ren, icache_abort,
        input  icache_dout, icache_dout_valid,
        output dispatch_pcout_plus4, dispatch_inst, dispatch_empty, ifq_count,
        input  dispatch_ren, dispatch_branch_addr, dispatch_branch_valid
    );

    modport slave (
        input  icache_pcin, icache_ren, icache_abort,
        output icache_dout, icache_dout_valid,
        input  dispatch_pcout_plus4, dispatch_inst, dispatch_empty, ifq_count,
        output dispatch_ren, dispatch_branch_addr, dispatch_branch_valid
    );
endinterface

// File: rtl/ifq_multiline.sv
// Instruction fetch queue: buffers DEPTH icache lines of WPL words and hands
// one instruction per cycle to dispatch. At most one icache request is in
// flight; a branch flushes the queue, aborts an outstanding request and
// restarts fetching at the (possibly mid-line) target.
module ifq_multiline #(
    parameter int          DEPTH    = 4,
    parameter int          WPL      = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic             clk,
    input logic             reset,
    ifq_multiline_if.master bus
);
    localparam int SW = $clog2(DEPTH);      // line slot index bits
    localparam int LW = $clog2(WPL);        // word-in-line bits
    localparam int PW = SW + 1;             // line pointer incl. wrap bit
    localparam int RW = SW + LW + 1;        // word pointer incl. wrap bit
    localparam logic [31:0] LINE_BYTES = 32'(4 * WPL);

    typedef enum logic {FETCH, WAIT} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] wptr;                    // next line slot to fill
    logic [RW-1:0] rptr;                    // head word
    logic [31:0]   pcin;                    // address of next line to fetch
    logic [31:0]   pc_head;                 // PC of head word
    logic [31:0]   mem [DEPTH][WPL];

    logic [PW-1:0] rline;
    logic [RW-1:0] count;
    logic          full, empty;
    logic          ren, abort, fill, pop;

    // After a redirect rptr may sit mid-line while wptr still equals its line;
    // that state holds no valid words, so it must read as empty, not as a
    // negative difference.
    assign rline = rptr[RW-1:LW];
    assign full  = (wptr - rline) == PW'(DEPTH);
    assign count = (wptr == rline) ? '0 : ({wptr, {LW{1'b0}}} - rptr);
    assign empty = (count == '0);

    // Fetch FSM decode plus queue push/pop qualifiers.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        ren       = 1'b0;
        abort     = 1'b0;
        fill      = 1'b0;
        case (state)
            FETCH: begin
                // A request raised in a redirect cycle would carry the stale
                // pcin and nobody would abort it, so hold it off for a cycle.
                ren = ~full & ~bus.dispatch_branch_valid;
                if (ren) state_nxt = WAIT;
            end
            WAIT: begin
                ren = 1'b1;
                if (bus.dispatch_branch_valid) begin
                    abort = 1'b1;
                end else if (bus.icache_dout_valid) begin
                    fill      = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
        if (bus.dispatch_branch_valid) state_nxt = FETCH;
        pop = bus.dispatch_ren & ~empty & ~bus.dispatch_branch_valid;
        // Reset cancels the request silently: no abort, no fill, no request.
        if (reset) begin
            ren   = 1'b0;
            abort = 1'b0;
            fill  = 1'b0;
            pop   = 1'b0;
        end
    end

    // State, pointers and PCs; a branch overrides fill and pop.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
        if (reset) begin
            state   <= FETCH;
            wptr    <= '0;
            rptr    <= '0;
            pcin    <= RESET_PC;
            pc_head <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (bus.dispatch_branch_valid) begin
                wptr    <= '0;
                rptr    <= {{PW{1'b0}}, bus.dispatch_branch_addr[LW+1:2]};
                pcin    <= bus.dispatch_branch_addr & ~(LINE_BYTES - 32'd1);
                pc_head <= bus.dispatch_branch_addr;
            end else begin
                if (fill) begin
                    wptr <= wptr + PW'(1);
                    pcin <= pcin + LINE_BYTES;
                end
                if (pop) begin
                    rptr    <= rptr + RW'(1);
                    pc_head <= pc_head + 32'd4;
                end
            end
        end
    end

    // Line storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the line store has no reset; the pointers alone decide which words are valid.
        if (fill) begin
            for (int k = 0; k < WPL; k++) begin
                mem[wptr[SW-1:0]][k] <= bus.icache_dout[32*k +: 32];
            end
        end
    end

    assign bus.icache_pcin          = pcin;
    assign bus.icache_ren           = ren;
    assign bus.icache_abort         = abort;
    assign bus.dispatch_empty       = empty;
    assign bus.dispatch_inst        = empty ? 32'h0 : mem[rline[SW-1:0]][rptr[LW-1:0]];
    assign bus.dispatch_pcout_plus4 = pc_head + 32'd4;
    assign bus.ifq_count            = count;
endmodule

// File: tb/tb_ifq_multiline.sv
// Directed bench for ifq_multiline (DEPTH=4, WPL=4, RESET_PC=0). The
// stimulus side plays the icache and pushes each accepted instruction into a
// scoreboard; a negedge monitor pops and compares on every dispatch pop.
module tb_ifq_multiline;
    localparam int DEPTH = 4;
    localparam int WPL   = 4;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pcout;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    bit   serve_done = 1'b0;

    ifq_multiline_if #(.DEPTH(DEPTH), .WPL(WPL)) ifc();

    ifq_multiline #(.DEPTH(DEPTH), .WPL(WPL), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    always #5 clk = ~clk;

    // Instruction word stored at byte address a.
    function automatic logic [31:0] mk_inst(input logic [31:0] a);
        return 32'h5000_0000 + a;
    endfunction

    function automatic logic [32*WPL-1:0] mk_line(input logic [31:0] base);
        logic [32*WPL-1:0] l;
        for (int k = 0; k < WPL; k++) l[32*k +: 32] = mk_inst(base + 32'(4 * k));
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, answer it lat cycles after the request edge and
    // record the words dispatch should see (words below skip are dropped).
    task automatic serve_line(input int lat, input int skip, input bit chk_empty);
        logic [31:0] addr;
        int guard = 0;
        while (!ifc.icache_ren && guard < 300) begin
            step();
            guard++;
        end
        if (!ifc.icache_ren) begin
            total++;
            bad++;
            $display("FAIL serve_timeout: got ren=0 want ren=1 within 300 cycles");
            return;
        end
        addr = ifc.icache_pcin;
        step();
        repeat (lat - 1) step();
        ifc.icache_dout       = mk_line(addr);
        ifc.icache_dout_valid = 1'b1;
        for (int k = skip; k < WPL; k++) begin
            sb.push_back('{inst: mk_inst(addr + 32'(4 * k)), pcout: addr + 32'(4 * k + 4)});
        end
        if (chk_empty) begin
            #1;
            check("empty_on_valid_cycle", 32'(ifc.dispatch_empty), 32'd1);
        end
        step();
        ifc.icache_dout_valid = 1'b0;
    endtask

    task automatic pop_one();
        ifc.dispatch_ren = 1'b1;
        step();
        ifc.dispatch_ren = 1'b0;
        #1;
    endtask

    // Scoreboard monitor: compare every accepted pop, watch the occupancy bound.
    always @(negedge clk) begin
        if (!reset) begin
            if (ifc.dispatch_ren && !ifc.dispatch_empty && !ifc.dispatch_branch_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got inst %h want no instruction", ifc.dispatch_inst);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pop_inst", ifc.dispatch_inst, e.inst);
                    check("pop_pcout", ifc.dispatch_pcout_plus4, e.pcout);
                end
            end
            if (ifc.ifq_count > 5'd16) check("count_bound", 32'(ifc.ifq_count), 32'd16);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish before 400us");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                     = 1'b1;
        ifc.icache_dout           = '0;
        ifc.icache_dout_valid     = 1'b0;
        ifc.dispatch_ren          = 1'b0;
        ifc.dispatch_branch_addr  = '0;
        ifc.dispatch_branch_valid = 1'b0;
        repeat (3) step();

        // Reset state.
        check("rst_ren",   32'(ifc.icache_ren), 32'd0);
        check("rst_abort", 32'(ifc.icache_abort), 32'd0);
        check("rst_pcin",  ifc.icache_pcin, 32'h0);
        check("rst_empty", 32'(ifc.dispatch_empty), 32'd1);
        check("rst_inst",  ifc.dispatch_inst, 32'h0);
        check("rst_pcout", ifc.dispatch_pcout_plus4, 32'h4);
        check("rst_count", 32'(ifc.ifq_count), 32'd0);
        reset = 1'b0;
        #1;

        // First line two cycles after the request, then four pops.
        serve_line(2, 0, 1'b1);
        check("t1_empty_after", 32'(ifc.dispatch_empty), 32'd0);
        check("t1_count", 32'(ifc.ifq_count), 32'd4);
        check("t1_head_inst", ifc.dispatch_inst, 32'h5000_0000);
        ifc.dispatch_ren = 1'b1;
        repeat (4) step();
        ifc.dispatch_ren = 1'b0;
        #1;
        check("t1_count_drained", 32'(ifc.ifq_count), 32'd0);

        // Fill to full; the request stays off until the fourth pop frees a line.
        for (int i = 0; i < 4; i++) serve_line(1, 0, 1'b0);
        check("t2_count_full", 32'(ifc.ifq_count), 32'd16);
        check("t2_ren_full", 32'(ifc.icache_ren), 32'd0);
        for (int i = 0; i < 3; i++) begin
            pop_one();
            check("t2_ren_partial_pop", 32'(ifc.icache_ren), 32'd0);
        end
        pop_one();
        check("t2_ren_line_freed", 32'(ifc.icache_ren), 32'd1);
        check("t2_count_12", 32'(ifc.ifq_count), 32'd12);

        // Branch to 0x108 while WAIT, with the line arriving the same cycle.
        step();
        ifc.dispatch_branch_addr  = 32'h108;
        ifc.dispatch_branch_valid = 1'b1;
        ifc.icache_dout           = mk_line(32'h50);
        ifc.icache_dout_valid     = 1'b1;
        #1;
        check("t3_abort", 32'(ifc.icache_abort), 32'd1);
        sb.delete();
        step();
        ifc.dispatch_branch_valid = 1'b0;
        ifc.icache_dout_valid     = 1'b0;
        #1;
        check("t3_pcin", ifc.icache_pcin, 32'h100);
        check("t3_ren", 32'(ifc.icache_ren), 32'd1);
        check("t3_abort_clear", 32'(ifc.icache_abort), 32'd0);
        check("t3_empty", 32'(ifc.dispatch_empty), 32'd1);
        check("t3_count0", 32'(ifc.ifq_count), 32'd0);
        serve_line(2, 2, 1'b0);
        check("t3_inst", ifc.dispatch_inst, 32'h5000_0108);
        check("t3_pcout", ifc.dispatch_pcout_plus4, 32'h10C);
        check("t3_count2", 32'(ifc.ifq_count), 32'd2);

        // Branch + pop + line valid together while FETCH with data queued.
        ifc.dispatch_branch_addr  = 32'h200;
        ifc.dispatch_branch_valid = 1'b1;
        ifc.dispatch_ren          = 1'b1;
        ifc.icache_dout           = mk_line(32'h110);
        ifc.icache_dout_valid     = 1'b1;
        #1;
        check("t4_abort", 32'(ifc.icache_abort), 32'd0);
        sb.delete();
        step();
        ifc.dispatch_branch_valid = 1'b0;
        ifc.dispatch_ren          = 1'b0;
        ifc.icache_dout_valid     = 1'b0;
        #1;
        check("t4_empty", 32'(ifc.dispatch_empty), 32'd1);
        check("t4_count", 32'(ifc.ifq_count), 32'd0);
        check("t4_pcin", ifc.icache_pcin, 32'h200);
        check("t4_pcout", ifc.dispatch_pcout_plus4, 32'h204);

        // Reset in WAIT with the line returning during and after reset.
        step();
        reset = 1'b1;
        sb.delete();
        ifc.icache_dout       = mk_line(32'h200);
        ifc.icache_dout_valid = 1'b1;
        #1;
        check("t5_ren_in_reset", 32'(ifc.icache_ren), 32'd0);
        check("t5_abort_in_reset", 32'(ifc.icache_abort), 32'd0);
        step();
        ifc.icache_dout_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("t5_count", 32'(ifc.ifq_count), 32'd0);
        check("t5_pcin", ifc.icache_pcin, 32'h0);
        check("t5_empty", 32'(ifc.dispatch_empty), 32'd1);
        check("t5_inst", ifc.dispatch_inst, 32'h0);
        ifc.icache_dout_valid = 1'b1;
        step();
        ifc.icache_dout_valid = 1'b0;
        #1;
        check("t5_stale_empty", 32'(ifc.dispatch_empty), 32'd1);
        check("t5_stale_count", 32'(ifc.ifq_count), 32'd0);

        // Stream 12 lines with random pops across pointer wrap.
        fork
            begin
                for (int i = 0; i < 12; i++) serve_line(int'($urandom_range(1, 3)), 0, 1'b0);
                serve_done = 1'b1;
            end
            begin
                int guard = 0;
                while (!(serve_done && ifc.dispatch_empty) && guard < 3000) begin
                    ifc.dispatch_ren = ($urandom_range(0, 2) != 0);
                    step();
                    guard++;
                end
                ifc.dispatch_ren = 1'b0;
            end
        join
        step();
        check("t6_sb_drained", 32'(sb.size()), 32'd0);
        check("t6_count0", 32'(ifc.ifq_count), 32'd0);
        check("t6_pcin", ifc.icache_pcin, 32'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
